// File: rtl/eth_rx.sv
// eth_rx: RMII receive path. It strips the preamble and SFD, assembles bytes
// LSB first, checks the FCS with CRC-32 and holds back the last four bytes so
// the FCS never reaches the byte stream. It reports each frame end together
// with its error flags.
//
// Ports
//   Clk            in   50 MHz RMII reference clock
//   Rst            in   synchronous, active-high reset
//   Rxd[1:0]       in   receive dibit, Rxd[0] is the earlier bit on the wire
//   Crs_Dv         in   carrier sense / data valid
//   Rx_Byte[7:0]   out  received byte (destination address .. last pad byte)
//   Rx_Byte_Valid  out  one-cycle strobe per Rx_Byte
//   Rx_Sof         out  asserted with the first Rx_Byte_Valid of a frame
//   Rx_Eof         out  one-cycle end-of-frame strobe
//   Rx_Good        out  frame had no errors (qualified by Rx_Eof)
//   Rx_Err[2:0]    out  {align, len, crc} (qualified by Rx_Eof)
//
// state    | meaning
// IDLE     | waiting for the first preamble dibit
// PREAMBLE | counting preamble dibits, waiting for the SFD
// DATA     | assembling bytes, running the CRC, emitting delayed bytes
// DROP     | discarding the rest of the carrier (bad preamble or oversize)
module eth_rx #(
  parameter int pMIN_PRE = 8,
  parameter int pMIN_LEN = 64,
  parameter int pMAX_LEN = 1518
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [1:0] Rxd,
  input  logic       Crs_Dv,
  output logic [7:0] Rx_Byte,
  output logic       Rx_Byte_Valid,
  output logic       Rx_Sof,
  output logic       Rx_Eof,
  output logic       Rx_Good,
  output logic [2:0] Rx_Err
);

  localparam int          PRE_W    = $clog2(pMIN_PRE + 1);
  localparam logic [PRE_W-1:0] MIN_PRE = PRE_W'(pMIN_PRE);
  localparam logic [10:0] MIN_LEN  = 11'(pMIN_LEN);
  localparam logic [10:0] MAX_P1   = 11'(pMAX_LEN + 1);
  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
  localparam logic [31:0] RESIDUE  = 32'hDEBB20E3;

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  state_t           state;
  logic [PRE_W-1:0] pre_cnt;
  logic [1:0]       phase;
  logic [5:0]       shift;      // first three dibits of the byte being built
  logic [10:0]      byte_cnt;
  logic [31:0]      crc;
  logic [3:0][7:0]  dly;        // FCS hold-back line, dly[3] is the oldest
  logic             oversize;

  logic [7:0]  new_byte;
  logic [10:0] cnt_inc;
  logic [31:0] crc_next;
  logic        align_err;
  logic        len_err;
  logic        crc_err;

  function automatic logic [31:0] crc_update(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h000000, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  always_comb begin
    new_byte  = {Rxd, shift};
    cnt_inc   = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
    crc_next  = crc_update(crc, new_byte);
    align_err = (phase != 2'd0);
    len_err   = (byte_cnt < MIN_LEN);
    // a misaligned or short frame is never reported as having a good CRC
    crc_err   = (crc != RESIDUE) || len_err || align_err;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state         <= IDLE;
      pre_cnt       <= '0;
      phase         <= '0;
      shift         <= '0;
      byte_cnt      <= '0;
      crc           <= '0;
      dly           <= '0;
      oversize      <= 1'b0;
      Rx_Byte       <= '0;
      Rx_Byte_Valid <= 1'b0;
      Rx_Sof        <= 1'b0;
      Rx_Eof        <= 1'b0;
      Rx_Good       <= 1'b0;
      Rx_Err        <= '0;
    end else begin
      Rx_Byte_Valid <= 1'b0;
      Rx_Sof        <= 1'b0;
      Rx_Eof        <= 1'b0;
      Rx_Good       <= 1'b0;
      Rx_Err        <= '0;
      case (state)
        IDLE: begin
          if (Crs_Dv && Rxd == 2'b01) begin
            state   <= PREAMBLE;
            pre_cnt <= PRE_W'(1);
          end
        end
        PREAMBLE: begin
          oversize <= 1'b0;
          if (!Crs_Dv) begin
            state <= IDLE;
          end else if (Rxd == 2'b01) begin
            if (pre_cnt < MIN_PRE) pre_cnt <= pre_cnt + 1'b1;
          end else if (Rxd == 2'b11 && pre_cnt >= MIN_PRE) begin
            state    <= DATA;
            phase    <= '0;
            shift    <= '0;
            byte_cnt <= '0;
            crc      <= CRC_INIT;
          end else begin
            state <= DROP;
          end
        end
        DATA: begin
          if (!Crs_Dv) begin
            // whatever is still in dly is the FCS and is simply abandoned
            Rx_Eof  <= 1'b1;
            Rx_Err  <= {align_err, len_err, crc_err};
            Rx_Good <= ~crc_err;
            state   <= IDLE;
          end else begin
            phase <= phase + 2'd1;
            shift <= {Rxd, shift[5:2]};
            if (phase == 2'd3) begin
              byte_cnt <= cnt_inc;
              crc      <= crc_next;
              dly      <= {dly[2:0], new_byte};
              if (cnt_inc == MAX_P1) begin
                state    <= DROP;
                oversize <= 1'b1;
              end else if (byte_cnt >= 11'd4) begin
                Rx_Byte       <= dly[3];
                Rx_Byte_Valid <= 1'b1;
                Rx_Sof        <= (byte_cnt == 11'd4);
              end
            end
          end
        end
        DROP: begin
          if (!Crs_Dv) begin
            state    <= IDLE;
            oversize <= 1'b0;
            if (oversize) begin
              Rx_Eof <= 1'b1;
              Rx_Err <= 3'b011;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
